// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters share one combinational ALU through an IDLE/EXEC/RESP handshake.
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins); default is round-robin.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_ctr,
  input  logic [2:0]       req1_ctr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_co,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic [2:0]       rsp_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       ctr_q, ctr_d, flags_q, flags_d;
  logic             id_q, id_d;
  logic             any_req, gnt_id, accept;

  assign any_req = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt_id = ~req0_valid;
`else
  logic last_q;
  // last_q resets to 1 so req0 wins the first contention
  assign gnt_id = (req0_valid & req1_valid) ? ~last_q : req1_valid;

  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= gnt_id;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = ~rst & any_req & ~gnt_id;
        req1_ready = ~rst & any_req &  gnt_id;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = req0_ready | req1_ready;

  // Operands are frozen at accept time; the ALU only ever sees the latched copy.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ctr_d   = ctr_q;
    id_d    = id_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (accept) begin
      a_d   = gnt_id ? req1_a   : req0_a;
      b_d   = gnt_id ? req1_b   : req0_b;
      ctr_d = gnt_id ? req1_ctr : req0_ctr;
      id_d  = gnt_id;
    end
    if (state_q == EXEC) begin
      res_d   = alu_res;
      flags_d = {alu_ovf, alu_zero, alu_co};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      ctr_q   <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      ctr_q   <= ctr_d;
      id_q    <= id_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctr   = ctr_q;
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: scoreboard bench for alu_share_arb with a behavioural ALU and arbitration model.
module tb_alu_share_arb;
  localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_ctr = '0, req1_ctr = '0, alu_ctr;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic alu_co, alu_zero, alu_ovf;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [W-1:0] rsp_res;
  logic [2:0] rsp_flags;

  always #5 clk = ~clk;

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ctr(req0_ctr), .req1_ctr(req1_ctr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_res(alu_res), .alu_co(alu_co), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags)
  );

  // Team ALU: 3'b110 subtracts, everything else adds; returns {ovf, zero, co, res}.
  function automatic logic [W+2:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] ctr);
    logic [W:0] s;
    logic ovf;
    if (ctr == 3'b110) begin
      s   = {1'b0, a} - {1'b0, b};
      ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      s   = {1'b0, a} + {1'b0, b};
      ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
    return {ovf, (s[W-1:0] == '0), s[W], s[W-1:0]};
  endfunction

  assign {alu_ovf, alu_zero, alu_co, alu_res} = alu_fn(alu_a, alu_b, alu_ctr);

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [2:0] ctr; } op_t;
  typedef struct { logic id; logic [W-1:0] res; logic [2:0] fl; int unsigned acc; } exp_t;

  op_t  op0_q[$], op1_q[$];
  exp_t exp_q[$];
  int   g_log[$];
  int unsigned g_cyc[$];
  int unsigned cyc = 0, hs_cyc = 0;
  int   tests = 0, errors = 0, n_rsp = 0;
  bit   free_m = 1'b1, last_g = 1'b1, in_rsp = 1'b0, acc0 = 1'b0, acc1 = 1'b0, rnd_rdy = 1'b0;
  logic [W-1:0] last_res = '0;
  logic last_id = 1'b0;
  logic [2:0] last_fl = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: transaction-level model of who may be granted and what must come back.
  always @(negedge clk) begin
    exp_t e;
    logic [W+2:0] r;
    logic eid;
    if (rst) begin
      chk("ready_in_reset", 64'({req1_ready, req0_ready}), 64'(2'b00));
      exp_q.delete();
      free_m = 1'b1; last_g = 1'b1; in_rsp = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      if (free_m && (req0_valid || req1_valid)) begin
        eid = (req0_valid && req1_valid) ? (FIXED ? 1'b0 : ~last_g) : req1_valid;
        chk("grant", 64'({req1_ready, req0_ready}), eid ? 64'(2'b10) : 64'(2'b01));
        r = eid ? alu_fn(req1_a, req1_b, req1_ctr) : alu_fn(req0_a, req0_b, req0_ctr);
        e.id = eid; e.res = r[W-1:0]; e.fl = r[W+2:W]; e.acc = cyc;
        exp_q.push_back(e);
        last_g = eid; free_m = 1'b0;
      end else begin
        chk("no_grant", 64'({req1_ready, req0_ready}), 64'(2'b00));
      end
      if (req0_ready && req0_valid) begin acc0 = 1'b1; g_log.push_back(0); g_cyc.push_back(cyc); end
      if (req1_ready && req1_valid) begin acc1 = 1'b1; g_log.push_back(1); g_cyc.push_back(cyc); end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(1'b0));
        end else begin
          if (!in_rsp) begin
            chk("latency", 64'(cyc - exp_q[0].acc), 64'(2));
            in_rsp = 1'b1;
          end
          chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
          chk("rsp_res", 64'(rsp_res), 64'(exp_q[0].res));
          chk("rsp_flags", 64'(rsp_flags), 64'(exp_q[0].fl));
          if (rsp_ready) begin
            last_res = rsp_res; last_id = rsp_id; last_fl = rsp_flags;
            hs_cyc = cyc; n_rsp++;
            void'(exp_q.pop_front());
            in_rsp = 1'b0; free_m = 1'b1;
          end
        end
      end
    end
  end

  // Requester drivers: hold valid until accepted, then scramble operands or load the next op.
  always @(posedge clk) begin
    op_t o;
    #1;
    if (acc0) begin acc0 = 1'b0; req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; end
    if (!req0_valid && op0_q.size() > 0) begin
      o = op0_q.pop_front();
      req0_a = o.a; req0_b = o.b; req0_ctr = o.ctr; req0_valid = 1'b1;
    end
    if (acc1) begin acc1 = 1'b0; req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; end
    if (!req1_valid && op1_q.size() > 0) begin
      o = op1_q.pop_front();
      req1_a = o.a; req1_b = o.b; req1_ctr = o.ctr; req1_valid = 1'b1;
    end
    if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic push_op(input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c);
    op_t o;
    o.a = a; o.b = b; o.ctr = c;
    if (n) op1_q.push_back(o);
    else   op0_q.push_back(o);
  endtask

  task automatic wait_grants(input int n);
    int k = 0;
    while (g_log.size() < n && k < 200) begin @(posedge clk); k++; end
    if (g_log.size() < n) chk("grant_timeout", 64'(g_log.size()), 64'(n));
  endtask

  task automatic drain();
    int k = 0;
    while ((op0_q.size() > 0 || op1_q.size() > 0 || req0_valid || req1_valid ||
            exp_q.size() > 0) && k < 2000) begin
      @(posedge clk); k++;
    end
    repeat (2) @(posedge clk);
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int base, nr;
  int k;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_res", 64'(rsp_res), 64'(0));
    chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    chk("rst_alu_a", 64'(alu_a), 64'(0));
    chk("rst_alu_b", 64'(alu_b), 64'(0));
    chk("rst_alu_ctr", 64'(alu_ctr), 64'(0));

    // Contention straight out of reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_op(1'b0, $urandom, $urandom, 3'b010);
      push_op(1'b1, $urandom, $urandom, 3'b110);
    end
    base = g_log.size();
    wait_grants(base + 4);
    for (int i = 0; i < 4; i++)
      chk("contention_order", 64'(g_log[base+i]), FIXED ? 64'(0) : 64'(i % 2));
    drain();

    // Lone req0 add; a req1 pulse while busy must leave no trace.
    base = g_log.size(); nr = n_rsp;
    push_op(1'b0, 32'd22222, 32'd11111, 3'b010);
    wait_grants(base + 1);
    #2 req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_ctr = 3'b010;
    @(posedge clk); #2 req1_valid = 1'b0;
    drain();
    repeat (4) @(posedge clk);
    chk("s1_res", 64'(last_res), 64'(33333));
    chk("s1_id", 64'(last_id), 64'(0));
    chk("s1_flags", 64'(last_fl), 64'(3'b000));
    chk("s1_one_grant", 64'(g_log.size() - base), 64'(1));
    chk("s1_one_rsp", 64'(n_rsp - nr), 64'(1));

    // Lone req1 subtract to zero.
    push_op(1'b1, 32'd11111, 32'd11111, 3'b110);
    drain();
    chk("s2_res", 64'(last_res), 64'(0));
    chk("s2_id", 64'(last_id), 64'(1));
    chk("s2_zero", 64'(last_fl[1]), 64'(1));

    // Signed overflow on add.
    push_op(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b010);
    drain();
    chk("s6_res", 64'(last_res), 64'(32'h8000_0000));
    chk("s6_ovf", 64'(last_fl[2]), 64'(1));
    chk("s6_co", 64'(last_fl[0]), 64'(0));

    // Consumer stall with req1 waiting.
    rsp_ready = 1'b0;
    base = g_log.size();
    push_op(1'b0, $urandom, $urandom, 3'b010);
    wait_grants(base + 1);
    push_op(1'b1, $urandom, $urandom, 3'b110);
    k = 0;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    chk("s4_rsp_seen", 64'(rsp_valid), 64'(1));
    repeat (5) @(posedge clk);
    chk("s4_req1_held", 64'(req1_ready), 64'(0));
    #1 rsp_ready = 1'b1;
    wait_grants(base + 2);
    if (g_log.size() >= base + 2) begin
      chk("s4_next_id", 64'(g_log[base+1]), 64'(1));
      chk("s4_next_cyc", 64'(g_cyc[base+1] - hs_cyc), 64'(1));
    end
    drain();

    // Reset during EXEC discards the op and restores req0 preference.
    base = g_log.size(); nr = n_rsp;
    push_op(1'b0, $urandom, $urandom, 3'b010);
    wait_grants(base + 1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("s5_no_rsp", 64'(n_rsp - nr), 64'(0));
    base = g_log.size();
    push_op(1'b0, $urandom, $urandom, 3'b110);
    push_op(1'b1, $urandom, $urandom, 3'b010);
    wait_grants(base + 1);
    if (g_log.size() > base) chk("s5_first_grant", 64'(g_log[base]), 64'(0));
    drain();

    // Random traffic with random consumer back-pressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      push_op($urandom_range(0, 1) == 1, a, b, ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b010);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();
    rnd_rdy = 1'b0;
    #1 rsp_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arb.md
ALU_SHARE_ARB -- requirements
Module: alu_share_arb

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be 32 in this codebase.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-004 req0_valid/req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready/req1_ready  output  1  operation of requester N accepted this cycle.
REQ-006 req0_a/req1_a, req0_b/req1_b  input  WIDTH  operands A and B.
REQ-007 req0_ctr/req1_ctr  input  3  ALU_Ctr opcode, passed through unmodified.
REQ-008 alu_a, alu_b  output  WIDTH; alu_ctr  output  3  drive the shared ALU's A, B and ALU_Ctr.
REQ-009 alu_res  input  WIDTH; alu_co, alu_zero, alu_ovf  input  1  shared ALU's res, Co, zero and overflow.
REQ-010 rsp_valid  output  1  result available; rsp_ready  input  1  consumer accepts.
REQ-011 rsp_id  output  1  requester that owns the result; rsp_res  output  WIDTH  result.
REQ-012 rsp_flags  output  3  {overflow, zero, Co} captured with the result.

Function
REQ-013 FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-014 IDLE: if any reqN_valid, grant one requester, assert only its reqN_ready combinationally, and latch a, b, ctr and id on that edge; next state EXEC.
REQ-015 reqN_ready SHALL be 0 in EXEC and RESP and for any non-granted requester.
REQ-016 alu_a/alu_b/alu_ctr SHALL come from the latched registers only, so the ALU sees stable inputs for the whole operation.
REQ-017 EXEC lasts exactly one cycle: alu_res and flags are registered into rsp_res/rsp_flags; next state RESP.
REQ-018 RESP: rsp_valid=1; rsp_res, rsp_flags and rsp_id SHALL hold until rsp_valid && rsp_ready; then next state IDLE.
REQ-019 Latency: if accepted at edge N, rsp_valid SHALL be 1 from edge N+2. Back-to-back throughput is one op per 3 cycles with rsp_ready held 1.
REQ-020 Arbitration (default): round-robin. A last_grant bit records the last granted id. If both requests are valid, the id != last_grant wins. A lone valid request always wins.
REQ-021 rsp_ready stalls of any length SHALL not lose or alter the result. New requests are not accepted during the stall.
REQ-022 reqN_valid deasserted before grant SHALL have no effect; no request is buffered internally.
REQ-023 Output ports a/b/ctr and rsp_res SHALL not be modified by requester input changes after acceptance.

Reset
REQ-024 When rst=1 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0, latched a/b/ctr=0, last_grant=1 (so req0 wins the first contention).
REQ-025 Reset mid-operation (EXEC or RESP) SHALL discard the in-flight operation; rsp_valid SHALL be 0 on the cycle after the reset edge; reqN_ready SHALL be 0 while rst=1.

Configuration
REQ-026 Macro ALU_ARB_FIXED_PRIO_EN. If defined, arbitration SHALL be fixed priority, with req0 always winning over req1 and last_grant unused. If undefined, round-robin per REQ-020 applies. All other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL use the team ALU opcodes: 3'b010 add, 3'b110 sub.
REQ-028 Scenario 1: req0 only, a=22222, b=11111, ctr=3'b010, rsp_ready=1.
- Required response: req0_ready pulses once; rsp_valid=1 two cycles later.
- rsp_res=33333, rsp_id=0, rsp_flags=3'b000.
REQ-029 Scenario 2: req1 only, a=11111, b=11111, ctr=3'b110.
- Required response: rsp_res=0, rsp_id=1, rsp_flags zero bit=1.
REQ-030 Scenario 3: both requests valid continuously after reset, rsp_ready=1, round-robin build.
- Required response: grants alternate 0,1,0,1.
- With ALU_ARB_FIXED_PRIO_EN defined: grants are 0,0,0,0.
REQ-031 Scenario 4: hold rsp_ready=0 for 5 cycles while req1_valid=1.
- Required response: rsp_valid, rsp_res and rsp_id stay constant; req1_ready stays 0.
- After rsp_ready=1 the handshake completes; req1 is accepted the next cycle.
REQ-032 Scenario 5: assert rst for one cycle during EXEC.
- Required response: rsp_valid stays 0; the next grant after reset goes to req0 under contention.
REQ-033 Scenario 6: a=32'h7FFFFFFF, b=1, ctr=3'b010.
- Required response: rsp_res=32'h80000000, overflow flag=1, Co=0.
